hex_scan_ctrl: RTL
==================

HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4: clocks spent per digit slot (legal values >= 2).
REQ-002 SHALL have parameter BLINK_DIV, default 8: full sweeps per blink-phase toggle (legal values >= 1).
REQ-003 SHALL have port Clk  input  1  sole clock, all state on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req0/req1  input  1  write request from requester 0/1, held until granted.
REQ-006 SHALL have ports idx0/idx1  input  3  target digit index 0..5.
REQ-007 SHALL have ports val0/val1  input  4  hex nibble to display.
REQ-008 SHALL have ports blank0/blank1 and blink0/blink1  input  1  per-digit blank and blink attributes.
REQ-009 SHALL have ports gnt0/gnt1  output  1  combinational grant, at most one high per cycle.
REQ-010 SHALL have port err  output  1  sticky flag for a granted write with index > 5.
REQ-011 SHALL have ports HEX0..HEX5  output  7  registered, active-low segment patterns.

Function
REQ-012 SHALL keep a 6-entry digit table; each entry holds value[3:0], blank and blink.
REQ-013 SHALL grant the only requester when one reqN is high, in the same cycle.
REQ-014 SHALL, when both requests are high, grant the requester not granted most recently (round-robin).
REQ-015 SHALL update the round-robin pointer only on a cycle that has a grant.
REQ-016 SHALL write {valN, blankN, blinkN} into entry idxN on the clock edge ending a cycle in which gntN is high.
REQ-017 SHALL, for a granted write with idxN of 6 or 7, complete the grant, leave the table unchanged and set err to 1 until reset.
REQ-018 SHALL run a divider counting 0..SCAN_DIV-1 and a digit pointer counting 0..5.
REQ-019 SHALL, at each edge where the divider equals SCAN_DIV-1, load HEX[pointer] and advance the pointer, wrapping from 5 to 0.
REQ-020 SHALL load HEX[pointer] with 7'h7F if the entry is blank, or if blink=1 and blink_phase=1.
REQ-021 SHALL otherwise load HEX[pointer] with the shared decoder output for that entry's value.
REQ-022 SHALL use the standard active-low table, where 0 decodes to 7'h40 and F to 7'h0E.
REQ-023 SHALL count completed sweeps (pointer wraps 5->0) and toggle blink_phase on every BLINK_DIV-th wrap.
REQ-024 SHALL, when a write and a refresh hit the same digit in the same cycle, show the pre-write value; the new value appears on the next sweep.
REQ-025 SHALL reflect any write on HEX within 6*SCAN_DIV+1 cycles of the granting edge.
REQ-026 SHALL leave every HEX output not being refreshed unchanged.

Reset
REQ-027 SHALL, on Reset high and independent of Clk, set all entries to value=0, blank=1, blink=0.
REQ-028 SHALL, on reset, set HEX0..HEX5 to 7'h7F, divider/pointer/sweep counter to 0, blink_phase=0 and err=0.
REQ-029 SHALL, on reset, set the round-robin pointer so that requester 0 wins the first contention.
REQ-030 SHALL hold gnt0/gnt1 low while Reset is high.
REQ-031 SHALL abandon any in-progress sweep on reset mid-operation, with no partial HEX update after reset.

Structure
REQ-032 SHALL place NUM_DIGITS=6, SEG_BLANK=7'h7F and the digit_t struct {value, blank, blink} in shared package hex_pkg.
REQ-033 SHALL instantiate exactly one HexDriver as the shared decoder, its input muxed from table[pointer].
REQ-034 SHALL be implemented with no other sub-modules.

Verification
REQ-035 SHALL test reset then idle: all HEX stay 7'h7F for 3 sweeps, gnt0/gnt1 low, err=0.
REQ-036 SHALL test req0 idx=2 val=A blank=0: gnt0 same cycle; HEX2=7'h08 within 25 cycles (SCAN_DIV=4); others remain 7'h7F.
REQ-037 SHALL test req0 and req1 held 4 cycles: grants alternate 0,1,0,1, with requester 1's final write to the shared index displayed.
REQ-038 SHALL test req1 idx=7: gnt1 high, err=1 and stays 1, table unchanged, HEX unchanged.
REQ-039 SHALL test digit 0 val=8 blink=1 with BLINK_DIV=2: HEX0 alternates 7'h00 / 7'h7F every 2 sweeps (48 cycles).
REQ-040 SHALL test Reset asserted mid-sweep after writes: HEX0..HEX5 read 7'h7F immediately and remain so after release until a new write.

Source files
------------

// File: rtl/hex_pkg.sv
// Shared types and constants for the six-digit multiplexed hex display controller.
package hex_pkg;

   localparam int NUM_DIGITS = 6;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef struct packed {
      logic [3:0] value;
      logic       blank;
      logic       blink;
   } digit_t;

   localparam digit_t DIGIT_RESET = '{value: 4'h0, blank: 1'b1, blink: 1'b0};

endpackage

// File: rtl/hex_scan_ctrl_hexdriver.sv
// Nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module HexDriver (
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = 7'h7F;
      case (nibble_i)
         4'h0: seg_o = 7'h40;
         4'h1: seg_o = 7'h79;
         4'h2: seg_o = 7'h24;
         4'h3: seg_o = 7'h30;
         4'h4: seg_o = 7'h19;
         4'h5: seg_o = 7'h12;
         4'h6: seg_o = 7'h02;
         4'h7: seg_o = 7'h78;
         4'h8: seg_o = 7'h00;
         4'h9: seg_o = 7'h10;
         4'hA: seg_o = 7'h08;
         4'hB: seg_o = 7'h03;
         4'hC: seg_o = 7'h46;
         4'hD: seg_o = 7'h21;
         4'hE: seg_o = 7'h06;
         4'hF: seg_o = 7'h0E;
         default: seg_o = 7'h7F;
      endcase
   end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Two-requester digit table with round-robin write arbitration and a
// one-digit-per-slot scan refresh of six registered HEX outputs with blinking.
module hex_scan_ctrl
   import hex_pkg::*;
#(
   parameter int SCAN_DIV  = 4,
   parameter int BLINK_DIV = 8
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       req0,
   input  logic       req1,
   input  logic [2:0] idx0,
   input  logic [2:0] idx1,
   input  logic [3:0] val0,
   input  logic [3:0] val1,
   input  logic       blank0,
   input  logic       blank1,
   input  logic       blink0,
   input  logic       blink1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       err,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic [6:0] HEX2,
   output logic [6:0] HEX3,
   output logic [6:0] HEX4,
   output logic [6:0] HEX5
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int SWP_W = $clog2(BLINK_DIV + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [SWP_W-1:0] SWP_LAST = SWP_W'(BLINK_DIV - 1);
   localparam logic [2:0]       PTR_LAST = 3'(NUM_DIGITS - 1);

   digit_t           table_q [NUM_DIGITS];
   digit_t           table_d [NUM_DIGITS];
   logic [6:0]       hex_q   [NUM_DIGITS];
   logic [6:0]       hex_d   [NUM_DIGITS];
   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       ptr_q, ptr_d;
   logic [SWP_W-1:0] swp_q, swp_d;
   logic             phase_q, phase_d;
   logic             err_q, err_d;
   logic             last_q, last_d;   // requester granted most recently

   digit_t           cur_digit;
   logic [6:0]       dec_seg;
   logic [6:0]       load_seg;

   // Reset value of last_q is 1 so requester 0 wins the first contention.
   assign gnt0 = !Reset && req0 && (!req1 || last_q);
   assign gnt1 = !Reset && req1 && (!req0 || !last_q);

   always_comb begin
      last_d = last_q;
      if (gnt1) begin
         last_d = 1'b1;
      end else if (gnt0) begin
         last_d = 1'b0;
      end
   end

   // Out-of-range indices match no entry, so the write is dropped and flagged.
   always_comb begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
         table_d[i] = table_q[i];
         if (gnt0 && idx0 == 3'(i)) begin
            table_d[i] = '{value: val0, blank: blank0, blink: blink0};
         end
         if (gnt1 && idx1 == 3'(i)) begin
            table_d[i] = '{value: val1, blank: blank1, blink: blink1};
         end
      end
      err_d = err_q | (gnt0 && idx0 > PTR_LAST) | (gnt1 && idx1 > PTR_LAST);
   end

   always_comb begin
      cur_digit = table_q[0];
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (ptr_q == 3'(i)) begin
            cur_digit = table_q[i];
         end
      end
   end

   HexDriver u_dec (
      .nibble_i (cur_digit.value),
      .seg_o    (dec_seg)
   );

   assign load_seg = (cur_digit.blank || (cur_digit.blink && phase_q)) ? SEG_BLANK : dec_seg;

   // Refresh reads table_q, so a same-cycle write to this digit shows next sweep.
   always_comb begin
      div_d   = div_q;
      ptr_d   = ptr_q;
      swp_d   = swp_q;
      phase_d = phase_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         hex_d[i] = hex_q[i];
      end
      if (div_q == DIV_LAST) begin
         div_d = '0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (ptr_q == 3'(i)) begin
               hex_d[i] = load_seg;
            end
         end
         if (ptr_q == PTR_LAST) begin
            ptr_d = '0;
            if (swp_q == SWP_LAST) begin
               swp_d   = '0;
               phase_d = ~phase_q;
            end else begin
               swp_d = swp_q + 1'b1;
            end
         end else begin
            ptr_d = ptr_q + 1'b1;
         end
      end else begin
         div_d = div_q + 1'b1;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            table_q[i] <= DIGIT_RESET;
            hex_q[i]   <= SEG_BLANK;
         end
         div_q   <= '0;
         ptr_q   <= '0;
         swp_q   <= '0;
         phase_q <= 1'b0;
         err_q   <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            table_q[i] <= table_d[i];
            hex_q[i]   <= hex_d[i];
         end
         div_q   <= div_d;
         ptr_q   <= ptr_d;
         swp_q   <= swp_d;
         phase_q <= phase_d;
         err_q   <= err_d;
         last_q  <= last_d;
      end
   end

   assign err  = err_q;
   assign HEX0 = hex_q[0];
   assign HEX1 = hex_q[1];
   assign HEX2 = hex_q[2];
   assign HEX3 = hex_q[3];
   assign HEX4 = hex_q[4];
   assign HEX5 = hex_q[5];

endmodule
